// File: rtl/add_accum.sv
// Frame accumulator: sums COUNT unsigned samples into a saturating total
// and holds that total on a valid/ready port until the consumer takes it.
`timescale 1ns/1ps
module add_accum #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int COUNT     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  input  logic                 out_ready,
  output logic                 busy
);
  localparam int CW = $clog2(COUNT);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t               state, state_nx;
  logic [ACC_WIDTH-1:0] acc, acc_nx, out_data_nx, sat;
  logic [CW-1:0]        cnt, cnt_nx;
  logic                 ovf, ovf_nx, out_ovf_nx;
  logic [ACC_WIDTH:0]   sum;
  logic                 clip, accept, last;

  // One spare bit catches the carry that means the total would wrap.
  assign sum    = {1'b0, acc} + {{(ACC_WIDTH+1-WIDTH){1'b0}}, in_data};
  assign clip   = sum[ACC_WIDTH];
  assign sat    = clip ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];

  assign in_ready  = (state == ACCUM) && !rst;
  assign out_valid = (state == HOLD);
  assign busy      = ((state == ACCUM) && (cnt != '0)) || (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CW'(COUNT-1));

  always_comb begin
    state_nx    = state;
    acc_nx      = acc;
    cnt_nx      = cnt;
    ovf_nx      = ovf;
    out_data_nx = out_data;
    out_ovf_nx  = out_ovf;
    if (state == ACCUM) begin
      if (accept) begin
        if (last) begin
          out_data_nx = sat;
          out_ovf_nx  = ovf | clip;
          state_nx    = HOLD;
        end else begin
          acc_nx = sat;
          ovf_nx = ovf | clip;
          cnt_nx = cnt + 1'b1;
        end
      end
    end else if (out_ready) begin
      // Clearing here leaves a one-cycle bubble before the next frame starts.
      state_nx = ACCUM;
      acc_nx   = '0;
      cnt_nx   = '0;
      ovf_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACCUM;
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      state    <= state_nx;
      acc      <= acc_nx;
      cnt      <= cnt_nx;
      ovf      <= ovf_nx;
      out_data <= out_data_nx;
      out_ovf  <= out_ovf_nx;
    end
  end
endmodule

// File: tb/tb_add_accum.sv
// Bench for add_accum: a default instance and a 9-bit-accumulator instance
// share one stimulus stream; frame totals are predicted as plain integer sums.
`timescale 1ns/1ps
module tb_add_accum;
  localparam int COUNT = 4;
  localparam int MAX_A = 65535;
  localparam int MAX_B = 511;

  logic        clk, rst, in_valid, out_ready, chain;
  logic [7:0]  drv_data, in_data, add_a, add_b, add_sum;
  logic        in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic        in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [15:0] out_data_a;
  logic [8:0]  out_data_b;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int m_sum, m_cnt;
  bit m_hold;

  assign in_data = chain ? add_sum : drv_data;

  add_accum #(.WIDTH(8), .ACC_WIDTH(16), .COUNT(COUNT)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
    .out_ovf(out_ovf_a), .out_ready(out_ready), .busy(busy_a));

  add_accum #(.WIDTH(8), .ACC_WIDTH(9), .COUNT(COUNT)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
    .out_ovf(out_ovf_b), .out_ready(out_ready), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream registered adder used by the chained scenario.
  always @(posedge clk) add_sum <= add_a + add_b;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts accepted samples, predicts handshake state.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_sum = 0; m_cnt = 0; m_hold = 0;
      exp_q.delete();
    end else begin
      chk("busy_a", busy_a, (m_cnt != 0 || m_hold) ? 1 : 0);
      chk("busy_b", busy_b, (m_cnt != 0 || m_hold) ? 1 : 0);
      chk("in_ready_a", in_ready_a, m_hold ? 0 : 1);
      chk("in_ready_b", in_ready_b, m_hold ? 0 : 1);
      chk("out_valid_a", out_valid_a, m_hold ? 1 : 0);
      chk("out_valid_b", out_valid_b, m_hold ? 1 : 0);
      if (out_valid_a && out_ready) m_hold = 0;
      else if (in_valid && in_ready_a) begin
        m_sum += int'(in_data);
        m_cnt++;
        if (m_cnt == COUNT) begin
          exp_q.push_back(m_sum);
          m_sum = 0; m_cnt = 0; m_hold = 1;
        end
      end
    end
  end

  // Monitor: compares every presented total against the queue head.
  always @(negedge clk) begin
    if (!rst && (out_valid_a || out_valid_b)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        int t;
        t = exp_q[0];
        chk("out_data_a", int'(out_data_a), (t > MAX_A) ? MAX_A : t);
        chk("out_ovf_a", int'(out_ovf_a), (t > MAX_A) ? 1 : 0);
        chk("out_data_b", int'(out_data_b), (t > MAX_B) ? MAX_B : t);
        chk("out_ovf_b", int'(out_ovf_b), (t > MAX_B) ? 1 : 0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present one sample after `gap` idle cycles and hold it until accepted.
  task automatic send(input int d, input int gap);
    bit done;
    int t;
    repeat (gap) begin in_valid = 1'b0; step(); end
    in_valid = 1'b1;
    drv_data = d[7:0];
    done = 0;
    t = 0;
    while (!done) begin
      @(negedge clk);
      done = in_ready_a;
      @(posedge clk); #1;
      t++;
      if (!done && t > 200) begin
        chk("send_timeout", 0, 1);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid_a | out_valid_b, 0);
    chk({tag, "_out_data"}, int'(out_data_a) + int'(out_data_b), 0);
    chk({tag, "_out_ovf"}, out_ovf_a | out_ovf_b, 0);
    chk({tag, "_busy"}, busy_a | busy_b, 0);
    chk({tag, "_in_ready"}, in_ready_a | in_ready_b, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; chain = 1'b0;
    drv_data = '0; add_a = '0; add_b = '0;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic frame, consumer always ready.
    out_ready = 1'b1;
    send(1, 0); send(1, 0); send(2, 0); send(3, 0);
    repeat (3) step();

    // Backpressure: producer keeps the next sample valid through HOLD.
    out_ready = 1'b0;
    send(5, 0); send(6, 0); send(7, 0); send(8, 0);
    in_valid = 1'b1; drv_data = 8'd4;
    repeat (5) step();
    out_ready = 1'b1;
    send(4, 0); send(4, 0); send(4, 0); send(4, 0);
    repeat (3) step();

    // Gaps of two idle cycles between samples.
    send(10, 0); send(20, 2); send(30, 2); send(40, 2);
    repeat (3) step();

    // Saturation in the narrow instance, then a clean frame.
    send(255, 0); send(255, 0); send(255, 0); send(255, 0);
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    repeat (3) step();

    // Asynchronous reset between edges mid-frame.
    send(50, 0); send(60, 0);
    #1 rst = 1'b1;
    #1 chk_zero("midreset");
    #1 rst = 1'b0;
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    repeat (3) step();

    // Chained through the registered adder.
    for (int k = 1; k <= 4; k++) begin
      add_a = 8'(k); add_b = 8'(k);
      step();
      chain = 1'b1;
      send(0, 0);
      chain = 1'b0;
    end
    repeat (3) step();

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      drv_data  = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
